// File: rtl/memory_stage.sv
// Pipeline MEM stage: EX/MEM register, data-cache handshake with stall generation,
// load/store lane formatting and the MEM/WB register feeding write-back.
module memory_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] aluResultE,
  input  logic [31:0] writeDataE,
  input  logic [31:0] pcPlus4E,
  input  logic [4:0]  rdE,
  input  logic        regWriteE,
  input  logic        memReadE,
  input  logic        memWriteE,
  input  logic [1:0]  resultSrcE,
  input  logic [2:0]  funct3E,
  output logic [31:0] aluResultM,
  output logic [4:0]  rdM,
  output logic        regWriteM,
  output logic        stallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] resultW,
  output logic [4:0]  rdW,
  output logic        regWriteW,
  output logic        accessErrW,
  output logic [31:0] stallCount
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      r_state;
  state_t      w_stateNext;

  logic [31:0] r_aluResultM;
  logic [31:0] r_writeDataM;
  logic [31:0] r_pcPlus4M;
  logic [4:0]  r_rdM;
  logic        r_regWriteM;
  logic        r_memReadM;
  logic        r_memWriteM;
  logic [1:0]  r_resultSrcM;
  logic [2:0]  r_funct3M;

  logic [31:0] r_resultW;
  logic [4:0]  r_rdW;
  logic        r_regWriteW;
  logic        r_accessErrW;
  logic [31:0] r_stallCount;

  logic        w_memOp;
  logic        w_isByte;
  logic        w_isHalf;
  logic        w_isWord;
  logic        w_badF3;
  logic        w_misaligned;
  logic        w_err;
  logic        w_memOk;
  logic [7:0]  w_loadByte;
  logic [15:0] w_loadHalf;
  logic [31:0] w_loadData;
  logic [31:0] w_result;

  // EX/MEM register: frozen while the cache access is outstanding
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aluResultM <= '0;
      r_writeDataM <= '0;
      r_pcPlus4M   <= '0;
      r_rdM        <= '0;
      r_regWriteM  <= 1'b0;
      r_memReadM   <= 1'b0;
      r_memWriteM  <= 1'b0;
      r_resultSrcM <= '0;
      r_funct3M    <= '0;
    end else if (!stallM) begin
      r_aluResultM <= aluResultE;
      r_writeDataM <= writeDataE;
      r_pcPlus4M   <= pcPlus4E;
      r_rdM        <= rdE;
      r_regWriteM  <= regWriteE;
      r_memReadM   <= memReadE;
      r_memWriteM  <= memWriteE;
      r_resultSrcM <= resultSrcE;
      r_funct3M    <= funct3E;
    end
  end

  always_comb begin
    w_isByte = 1'b0;
    w_isHalf = 1'b0;
    w_isWord = 1'b0;
    w_badF3  = 1'b0;
    case (r_funct3M)
      3'b000, 3'b100: w_isByte = 1'b1;
      3'b001, 3'b101: w_isHalf = 1'b1;
      3'b010:         w_isWord = 1'b1;
      default:        w_badF3  = 1'b1;
    endcase
  end

  assign w_memOp      = r_memReadM | r_memWriteM;
  assign w_misaligned = (w_isHalf & r_aluResultM[0]) | (w_isWord & (r_aluResultM[1:0] != 2'b00));
  assign w_err        = w_memOp & (w_badF3 | w_misaligned);
  assign w_memOk      = w_memOp & ~w_err;

  // The request is purely a function of the EX/MEM register; a completed op is
  // replaced in the same edge, so it can never be re-issued.
  assign mem_req  = w_memOk;
  assign stallM   = mem_req & ~mem_ready;
  assign mem_we   = w_memOk & r_memWriteM;
  assign mem_addr = {r_aluResultM[31:2], 2'b00};

  always_comb begin
    mem_wdata = r_writeDataM;
    mem_wstrb = 4'b0000;
    if (w_isByte) begin
      mem_wdata = {4{r_writeDataM[7:0]}};
    end else if (w_isHalf) begin
      mem_wdata = {2{r_writeDataM[15:0]}};
    end
    if (w_memOk && r_memWriteM) begin
      if (w_isByte) begin
        mem_wstrb = 4'b0001 << r_aluResultM[1:0];
      end else if (w_isHalf) begin
        mem_wstrb = r_aluResultM[1] ? 4'b1100 : 4'b0011;
      end else begin
        mem_wstrb = 4'b1111;
      end
    end
  end

  always_comb begin
    w_loadByte = mem_rdata[7:0];
    case (r_aluResultM[1:0])
      2'b00: w_loadByte = mem_rdata[7:0];
      2'b01: w_loadByte = mem_rdata[15:8];
      2'b10: w_loadByte = mem_rdata[23:16];
      2'b11: w_loadByte = mem_rdata[31:24];
      default: w_loadByte = mem_rdata[7:0];
    endcase
  end

  assign w_loadHalf = r_aluResultM[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  // funct3[2] selects zero-extension (LBU/LHU)
  always_comb begin
    w_loadData = mem_rdata;
    if (w_isByte) begin
      w_loadData = r_funct3M[2] ? {24'h0, w_loadByte} : {{24{w_loadByte[7]}}, w_loadByte};
    end else if (w_isHalf) begin
      w_loadData = r_funct3M[2] ? {16'h0, w_loadHalf} : {{16{w_loadHalf[15]}}, w_loadHalf};
    end
  end

  always_comb begin
    w_result = r_aluResultM;
    case (r_resultSrcM)
      2'b01:   w_result = w_loadData;
      2'b10:   w_result = r_pcPlus4M;
      default: w_result = r_aluResultM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: if (mem_req && !mem_ready) w_stateNext = S_BUSY;
      S_BUSY: if (mem_ready || !mem_req) w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  // MEM/WB register: a stalled cycle retires a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resultW    <= '0;
      r_rdW        <= '0;
      r_regWriteW  <= 1'b0;
      r_accessErrW <= 1'b0;
    end else if (stallM) begin
      r_regWriteW  <= 1'b0;
      r_accessErrW <= 1'b0;
    end else begin
      r_resultW    <= w_result;
      r_rdW        <= r_rdM;
      r_regWriteW  <= r_regWriteM & ~w_err;
      r_accessErrW <= w_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stallCount <= '0;
    end else if (stallM) begin
      r_stallCount <= r_stallCount + 32'd1;
    end
  end

  assign aluResultM = r_aluResultM;
  assign rdM        = r_rdM;
  assign regWriteM  = r_regWriteM;
  assign resultW    = r_resultW;
  assign rdW        = r_rdW;
  assign regWriteW  = r_regWriteW;
  assign accessErrW = r_accessErrW;
  assign stallCount = r_stallCount;

endmodule
